// File: rtl/cnn_pixel_streamer.sv
// cnn_pixel_streamer: frame RAM loaded over a write port, streamed out in raster order on start (row gaps via CNN_STREAM_ROW_GAP_EN)
module cnn_pixel_streamer #(
  parameter int I_F_BW = 8,
  parameter int IX = 28,
  parameter int IY = 28,
  parameter int ROW_GAP = 2,
  localparam int AW = $clog2(IX*IY)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [I_F_BW-1:0] i_wr_data,
  input  logic              i_start,
  input  logic              i_hold,
  output logic              o_valid,
  output logic [I_F_BW-1:0] o_pixel,
  output logic              o_sof,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_err
);
`ifdef CNN_STREAM_ROW_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam int XW = (IX > 1) ? $clog2(IX) : 1;
  localparam int YW = (IY > 1) ? $clog2(IY + 1) : 1;
  localparam int GW = $clog2(ROW_GAP + 2);
  typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;
  state_t state, state_nx;
  logic [I_F_BW-1:0] mem [IX*IY];
  logic [AW-1:0] addr;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [GW-1:0] gap_cnt;
  logic issue, row_end, last_pix, gap_end, wr_ok;
  // per-cycle control decode: read issue, row/frame boundaries, write acceptance
  always_comb begin
    issue    = (state == STREAM) && !i_hold;
    row_end  = col == XW'(IX - 1);
    last_pix = row_end && (row == YW'(IY - 1));
    gap_end  = gap_cnt == GW'(ROW_GAP - 1);
    wr_ok    = i_wr_en && (state == IDLE) && ({1'b0, i_wr_addr} < (AW+1)'(IX*IY));
  end
  // next-state: a row gap is only taken between rows, never after the last one
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = i_start ? STREAM : IDLE;
      STREAM:  state_nx = (issue && last_pix) ? DONE :
                          (issue && row_end && GAP_EN && ROW_GAP > 0) ? GAP : STREAM;
      GAP:     state_nx = gap_end ? STREAM : GAP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  // raster counters; the address runs alongside row/col so no multiplier is needed
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr    <= '0;
      col     <= '0;
      row     <= '0;
      gap_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE) begin
        addr <= '0;
        col  <= '0;
        row  <= '0;
      end else if (issue) begin
        addr <= addr + 1'b1;
        col  <= row_end ? '0 : col + 1'b1;
        row  <= row_end ? row + 1'b1 : row;
      end
    end
  // frame RAM write port; contents deliberately survive reset
  always_ff @(posedge clk)
    if (wr_ok) mem[i_wr_addr] <= i_wr_data;
  // registered stream outputs carry the synchronous RAM read data
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      o_valid  <= 1'b0;
      o_pixel  <= '0;
      o_sof    <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_wr_err <= 1'b0;
    end else begin
      o_valid  <= issue;
      o_sof    <= issue && (addr == '0);
      o_pixel  <= issue ? mem[addr] : o_pixel;
      o_busy   <= (state_nx != IDLE) || (state == DONE);
      o_done   <= state == DONE;
      o_wr_err <= i_wr_en && (state != IDLE);
    end
endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// tb_cnn_pixel_streamer: directed checks of load, stream, hold, restart/write-while-busy, abort and boundary writes
module tb_cnn_pixel_streamer;
  localparam int N = 784;
`ifdef CNN_STREAM_ROW_GAP_EN
  localparam int GX = 54;
`else
  localparam int GX = 0;
`endif
  logic clk = 1'b0, reset_n = 1'b1, i_wr_en = 1'b0, i_start = 1'b0, i_hold = 1'b0;
  logic [9:0] i_wr_addr = '0;
  logic [7:0] i_wr_data = '0;
  logic o_valid, o_sof, o_busy, o_done, o_wr_err;
  logic [7:0] o_pixel;
  logic [7:0] img [N];
  int tests = 0, fails = 0;
  int nv, pix_err, sof_err, first_c, done_c, busy_err, busy_after, done_after, err_cnt, err_c, gaps, last_v, abort_done, load_err;
  logic [7:0] first_pix, last_pix;

  cnn_pixel_streamer dut (
    .clk(clk), .reset_n(reset_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_hold(i_hold), .o_valid(o_valid), .o_pixel(o_pixel), .o_sof(o_sof),
    .o_busy(o_busy), .o_done(o_done), .o_wr_err(o_wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a frame at the current negedge and watches it cycle by cycle.
  // Cycle c counts cycles after the start edge; hold covers cycles hold_c..hold_c+4,
  // start_c re-pulses i_start, wr_c writes (wa,wd) (wr_c==0: together with start), abort_c pulls reset.
  task automatic run_frame(input int hold_c, input int start_c, input int wr_c, input int abort_c,
                           input logic [9:0] wa, input logic [7:0] wd);
    nv = 0; pix_err = 0; sof_err = 0; first_c = -1; done_c = -1; busy_err = 0; busy_after = -1;
    done_after = -1; err_cnt = 0; err_c = -1; gaps = 0; last_v = -1; abort_done = 0;
    first_pix = '0; last_pix = '0;
    i_start = 1'b1;
    if (wr_c == 0) begin i_wr_en = 1'b1; i_wr_addr = wa; i_wr_data = wd; end
    @(negedge clk);
    i_start = 1'b0; i_wr_en = 1'b0;
    for (int c = 1; c < 2000; c++) begin
      if (done_c >= 0) begin busy_after = o_busy; done_after = o_done; break; end
      if (o_valid) begin
        if (first_c < 0) begin first_c = c; first_pix = o_pixel; end
        if (nv >= N || o_pixel !== img[nv]) pix_err++;
        if (o_sof !== (nv == 0)) sof_err++;
        if (last_v >= 0) gaps += c - last_v - 1;
        last_v = c; last_pix = o_pixel; nv++;
      end else if (o_sof) sof_err++;
      if (o_wr_err) begin err_cnt++; err_c = c; end
      if (!o_busy) busy_err++;
      if (o_done) done_c = c;
      i_hold  = (c >= hold_c) && (c < hold_c + 5);
      i_start = (c == start_c);
      i_wr_en = (c == wr_c);
      if (c == wr_c) begin i_wr_addr = wa; i_wr_data = wd; end
      if (c == abort_c) begin
        i_hold = 1'b0; i_start = 1'b0; i_wr_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort_valid_async", o_valid, 0);
        chk("abort_busy_async", o_busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (900) begin
          @(negedge clk);
          if (o_done || o_valid) abort_done++;
        end
        break;
      end
      @(negedge clk);
    end
    i_hold = 1'b0; i_start = 1'b0; i_wr_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_sof", o_sof, 0);
    chk("rst_wr_err", o_wr_err, 0);
    chk("rst_pixel", o_pixel, 0);
    reset_n = 1'b1;
    @(negedge clk);
    load_err = 0;
    for (int a = 0; a < N; a++) begin
      img[a] = 8'(a % 256);
      i_wr_en = 1'b1; i_wr_addr = 10'(a); i_wr_data = img[a];
      @(negedge clk);
      if (o_wr_err) load_err++;
    end
    i_wr_en = 1'b0;
    @(negedge clk);
    if (o_wr_err) load_err++;
    chk("load_no_wr_err", load_err, 0);

    // T1 plain frame
    run_frame(-10, -1, -1, -1, '0, '0);
    chk("t1_first_valid_cycle", first_c, 2);
    chk("t1_first_pixel", first_pix, 0);
    chk("t1_sof", sof_err, 0);
    chk("t1_valid_count", nv, N);
    chk("t1_pixels", pix_err, 0);
    chk("t1_gaps", gaps, GX);
    chk("t1_done_cycle", done_c, 2 + N + GX);
    chk("t1_busy_during", busy_err, 0);
    chk("t1_busy_after", busy_after, 0);
    chk("t1_done_pulse_width", done_after, 0);
    chk("t1_no_wr_err", err_cnt, 0);
    repeat (3) @(negedge clk);

    // T2 hold for 5 cycles at pixel 100
    run_frame(101, -1, -1, -1, '0, '0);
    chk("t2_valid_count", nv, N);
    chk("t2_pixels", pix_err, 0);
    chk("t2_gaps", gaps, 5 + GX);
    chk("t2_done_cycle", done_c, 7 + N + GX);
    repeat (3) @(negedge clk);

    // T3 start while busy at pixel 300, write while busy at pixel 400
    run_frame(-10, 301, 401, -1, 10'd0, 8'hAA);
    chk("t3_valid_count", nv, N);
    chk("t3_pixels", pix_err, 0);
    chk("t3_done_cycle", done_c, 2 + N + GX);
    chk("t3_wr_err_count", err_cnt, 1);
    chk("t3_wr_err_cycle", err_c, 402);
    repeat (3) @(negedge clk);
    run_frame(-10, -1, -1, -1, '0, '0);
    chk("t3_pixel0_unchanged", first_pix, 8'h00);
    chk("t3_followup_pixels", pix_err, 0);
    repeat (3) @(negedge clk);

    // T4 reset mid-frame at pixel 500
    run_frame(-10, -1, -1, 501, '0, '0);
    chk("t4_no_done_or_valid_after_abort", abort_done, 0);
    run_frame(-10, -1, -1, -1, '0, '0);
    chk("t4_restart_first_pixel", first_pix, 0);
    chk("t4_restart_sof", sof_err, 0);
    chk("t4_restart_count", nv, N);
    chk("t4_restart_done_cycle", done_c, 2 + N + GX);
    repeat (3) @(negedge clk);

    // T5 write last address together with start, then out-of-range write
    img[783] = 8'h5A;
    run_frame(-10, -1, 0, -1, 10'd783, 8'h5A);
    chk("t5_last_pixel", last_pix, 8'h5A);
    chk("t5_pixels", pix_err, 0);
    chk("t5_valid_count", nv, N);
    repeat (3) @(negedge clk);
    i_wr_en = 1'b1; i_wr_addr = 10'd800; i_wr_data = 8'h33;
    @(negedge clk);
    i_wr_en = 1'b0;
    chk("t5_oob_no_wr_err", o_wr_err, 0);
    @(negedge clk);
    run_frame(-10, -1, -1, -1, '0, '0);
    chk("t5_oob_frame_pixels", pix_err, 0);
    chk("t5_oob_last_pixel", last_pix, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
